vram_bus_bridge: RTL

//  Bridges the CPU memory bus (address/data/we/start/busy/q handshake) to the CPU ports of
//  NUM_BANKS dual-port VRAM banks. GPU-side ports are untouched. Replaces per-bank hand wiring
//  in the top level. Adds address-window decode, configurable read latency, out-of-range

---
 rtl/vram_bridge_pkg.sv | 21 ++
 rtl/vram_addr_decode.sv | 28 ++
 rtl/vram_bus_bridge.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vram_bridge_pkg.sv
// Shared types and helpers for the VRAM bus bridges: FSM encodings, bank-select width, clog2.
// Pure declarations; no latency or flow control of its own.
package vram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam int SEL_W = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/vram_addr_decode.sv
// Splits a CPU bus address into window hit, bank select and in-bank word offset.
// Latency: combinational; backpressure: none.
module vram_addr_decode
    import vram_bridge_pkg::*;
#(
    parameter int              ADDR_W    = 27,
    parameter int              NUM_BANKS = 2,
    parameter int              BANK_AW   = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'hC000
) (
    input  logic [ADDR_W-1:0]  address,
    output logic               in_range,
    output logic [SEL_W-1:0]   sel,
    output logic [BANK_AW-1:0] offset
);

    logic [ADDR_W-1:0] local_addr;

    assign local_addr = address - BASE_ADDR;
    assign sel        = local_addr[BANK_AW +: SEL_W];
    assign offset     = local_addr[BANK_AW-1:0];

    // Bits above the select field must be clear, otherwise the window would alias upward.
    assign in_range = (address >= BASE_ADDR)
                   && ({1'b0, sel} < (SEL_W+1)'(NUM_BANKS))
                   && ((local_addr >> (BANK_AW + SEL_W)) == '0);

endmodule

// File: rtl/vram_bus_bridge.sv
// CPU memory bus to NUM_BANKS VRAM CPU ports; VRAM_MIRROR_EN adds write mirroring SRC->DST.
// Latency: write busy 1 cycle, read busy RD_LAT+1 cycles; start is ignored (not queued) while busy.
module vram_bus_bridge
    import vram_bridge_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 27,
    parameter int                NUM_BANKS  = 2,
    parameter int                BANK_AW    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'hC000,
    parameter int                RD_LAT     = 1,
    parameter int                MIRROR_SRC = 0,
    parameter int                MIRROR_DST = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           address,
    input  logic [DATA_W-1:0]           data,
    input  logic                        we,
    input  logic                        start,
    output logic                        busy,
    output logic [DATA_W-1:0]           q,
    output logic [BANK_AW-1:0]          bank_addr,
    output logic [DATA_W-1:0]           bank_d,
    output logic [NUM_BANKS-1:0]        bank_we,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_q
);

    localparam int CNT_W = clog2(RD_LAT + 1);

`ifdef VRAM_MIRROR_EN
    localparam bit MIRROR_ON = 1'b1;
`else
    localparam bit MIRROR_ON = 1'b0;
`endif

    state_t             state;
    logic               we_r;
    logic               in_range_r;
    logic [SEL_W-1:0]   sel_r;
    logic [CNT_W-1:0]   cnt;

    logic               dec_in_range;
    logic [SEL_W-1:0]   dec_sel;
    logic [BANK_AW-1:0] dec_offset;
    logic [NUM_BANKS-1:0] wr_mask;
    logic [DATA_W-1:0]  rd_word;

    vram_addr_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_BANKS (NUM_BANKS),
        .BANK_AW   (BANK_AW),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .address  (address),
        .in_range (dec_in_range),
        .sel      (dec_sel),
        .offset   (dec_offset)
    );

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (dec_sel == SEL_W'(i)) wr_mask[i] = 1'b1;
        end
        if (MIRROR_ON && (dec_sel == SEL_W'(MIRROR_SRC))) wr_mask[MIRROR_DST] = 1'b1;
        if (!dec_in_range) wr_mask = '0;
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (sel_r == SEL_W'(i)) rd_word = bank_q[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            q          <= '0;
            bank_addr  <= '0;
            bank_d     <= '0;
            bank_we    <= '0;
            we_r       <= 1'b0;
            in_range_r <= 1'b0;
            sel_r      <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bank_addr  <= dec_offset;
                        bank_d     <= data;
                        bank_we    <= we ? wr_mask : '0;
                        we_r       <= we;
                        in_range_r <= dec_in_range;
                        sel_r      <= dec_sel;
                        busy       <= 1'b1;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    bank_we <= '0;
                    if (we_r) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (RD_LAT <= 1) begin
                        state <= ST_CAPTURE;
                    end else begin
                        cnt   <= CNT_W'(RD_LAT - 2);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) state <= ST_CAPTURE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                ST_CAPTURE: begin
                    // Bank data is valid now that bank_addr has been held for RD_LAT cycles.
                    q     <= in_range_r ? rd_word : '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
